mul_share_arb: RTL and testbench
================================

MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
- REQ-001: Parameter NUM_REQ, default 4: number of requesters sharing the multiplier.
- REQ-002: Parameter DIN0_WIDTH, default 3: unsigned operand width.
- REQ-003: Parameter DIN1_WIDTH, default 8: signed operand width.
- REQ-004: Parameter DOUT_WIDTH, default 11: product width.
- REQ-005: Parameter ID_WIDTH, default 2: requester-index width, equal to ceil(log2(NUM_REQ)).
- REQ-006: Port ap_clk, input, 1: single clock; all state updates on its rising edge.
- REQ-007: Port ap_rst, input, 1: reset, synchronous and active-high.
- REQ-008: Port req_valid, input, NUM_REQ: bit i asserted means requester i offers an operand pair.
- REQ-009: Port req_ready, output, NUM_REQ: bit i asserted means requester i's operands are accepted this cycle.
- REQ-010: Port req_din0, input, NUM_REQ*DIN0_WIDTH: unsigned operand; requester i occupies bits [i*DIN0_WIDTH +: DIN0_WIDTH].
- REQ-011: Port req_din1, input, NUM_REQ*DIN1_WIDTH: signed two's-complement operand; packed the same way as req_din0.
- REQ-012: Port res_valid, output, 1: result register holds an unconsumed product.
- REQ-013: Port res_ready, input, 1: downstream accepts the result this cycle.
- REQ-014: Port res_dout, output, DOUT_WIDTH: registered product.
- REQ-015: Port res_id, output, ID_WIDTH: index of the requester that owns res_dout.
- REQ-016: Port grant_cnt, output, 16: count of accepted transactions; wraps modulo 2^16.

Function
- REQ-017: advance = !res_valid || res_ready; the arbiter grants only when advance is 1.
- REQ-018: Arbitration is round-robin: search from rr_ptr upward, modulo NUM_REQ, and grant the first index with req_valid set.
- REQ-019: req_ready is one-hot or zero, combinational, and equal to the grant vector ANDed with advance; it may depend on req_valid.
- REQ-020: Accept condition for requester i: req_valid[i] && req_ready[i].
- REQ-021: On accept, the block loads res_dout with the low DOUT_WIDTH bits of signed({1'b0,din0}) * signed(din1), loads res_id with i, and sets res_valid to 1.
- REQ-022: On accept, rr_ptr becomes (i+1) mod NUM_REQ and grant_cnt increments by 1; 16'hFFFF wraps to 0.
- REQ-023: Latency is 1 cycle: an accept in cycle N gives res_valid=1 with the product in cycle N+1.
- REQ-024: Throughput is one accept per cycle while res_ready=1.
- REQ-025: If advance=1 and no req_valid bit is set, res_valid is cleared next cycle; res_dout and res_id hold their values; rr_ptr and grant_cnt are unchanged.
- REQ-026: While res_valid=1 and res_ready=0, req_ready is all zero and res_dout/res_id are stable.
- REQ-027: Consume and accept in the same cycle (res_valid=1, res_ready=1, a request present) loads the new result with no bubble.
- REQ-028: rr_ptr is unchanged in any cycle with no accept.

Reset
- REQ-029: When ap_rst=1 at a clock edge, res_valid, res_dout, res_id, rr_ptr and grant_cnt are set to 0.
- REQ-030: While ap_rst=1, req_ready is forced to all zero and no accept occurs.
- REQ-031: Reset mid-operation discards any pending result without delivering it.
- REQ-032: The first cycle after reset deassertion arbitrates from index 0.

Verification
- REQ-033: Only requester 2 valid, din0=5, din1=8'hFD (-3), res_ready=1 -> next cycle res_valid=1, res_dout=11'h7F1 (-15), res_id=2, grant_cnt=1.
- REQ-034: Extremes, each issued alone: din0=7, din1=8'h80 -> res_dout=11'h480 (-896); din0=7, din1=8'h7F -> res_dout=11'h379 (889); din0=0, din1=8'h80 -> res_dout=0.
- REQ-035: All 4 requesters continuously valid, res_ready=1, 5 cycles -> res_id sequence 0,1,2,3,0 on consecutive cycles, grant_cnt=5.
- REQ-036: res_valid=1 then res_ready=0 for 3 cycles with all requesters valid -> req_ready=0, res_dout/res_id unchanged; res_ready=1 -> same-cycle grant to rr_ptr's requester, next result the following cycle.
- REQ-037: rr_ptr=2 with res_valid=1, one-cycle ap_rst -> res_valid=0, grant_cnt=0; then requesters 0 and 3 valid -> requester 0 granted first.
- REQ-038: Preload grant_cnt to 16'hFFFF via 65535 accepts, then one more accept -> grant_cnt=0.

Source files
------------

// File: rtl/mul_share_arb.sv
// Round-robin shared multiplier: NUM_REQ requesters time-share one unsigned x signed multiplier.
// Latency: 1 cycle from accept to registered product on res_dout/res_id with res_valid.
// Backpressure: while res_valid=1 and res_ready=0 no requester is granted and the result holds.
module mul_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 3,
  parameter int DIN1_WIDTH = 8,
  parameter int DOUT_WIDTH = 11,
  parameter int ID_WIDTH   = 2
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [DOUT_WIDTH-1:0]            res_dout,
  output logic [ID_WIDTH-1:0]              res_id,
  output logic [15:0]                      grant_cnt
);

  logic [ID_WIDTH-1:0]          rr_ptr;
  logic                         advance;
  logic                         found;
  logic [ID_WIDTH-1:0]          gnt_id;
  logic [NUM_REQ-1:0]           gnt;
  logic                         accept;
  logic [DIN0_WIDTH-1:0]        din0_sel;
  logic [DIN1_WIDTH-1:0]        din1_sel;
  logic signed [DOUT_WIDTH-1:0] op0_ext;
  logic signed [DOUT_WIDTH-1:0] op1_ext;
  logic signed [DOUT_WIDTH-1:0] prod;
  logic [ID_WIDTH-1:0]          rr_next;

  // The result slot can take a new product when empty or being drained this cycle.
  assign advance = !res_valid || res_ready;

  // Round-robin search: walk priorities k=0.. starting at rr_ptr, first valid requester wins.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req_valid[j] && ((int'(rr_ptr) + k) % NUM_REQ) == j) begin
          found  = 1'b1;
          gnt_id = ID_WIDTH'(j);
        end
      end
    end
  end

  // One-hot grant vector, gated by slot availability and held off during reset.
  always_comb begin
    gnt = '0;
    if (found) gnt[gnt_id] = 1'b1;
  end

  assign req_ready = (advance && !ap_rst) ? gnt : '0;
  assign accept    = |req_ready;

  // Operand mux and product: din0 is zero-extended (unsigned), din1 sign-extended.
  always_comb begin
    din0_sel = req_din0[gnt_id*DIN0_WIDTH +: DIN0_WIDTH];
    din1_sel = req_din1[gnt_id*DIN1_WIDTH +: DIN1_WIDTH];
    op0_ext  = DOUT_WIDTH'($signed({1'b0, din0_sel}));
    op1_ext  = DOUT_WIDTH'($signed(din1_sel));
    prod     = op0_ext * op1_ext;
  end

  // Pointer moves just past the winner so it gets lowest priority next time.
  assign rr_next = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  // Result register, round-robin pointer and accept counter.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      res_valid <= 1'b0;
      res_dout  <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
      grant_cnt <= '0;
    end else if (advance) begin
      if (accept) begin
        res_valid <= 1'b1;
        res_dout  <= prod;
        res_id    <= gnt_id;
        rr_ptr    <= rr_next;
        grant_cnt <= grant_cnt + 16'd1;
      end else begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with hand-computed products and grant order.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// Comparisons use immediate assertions; failures are counted and reported.
module tb_mul_share_arb;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_din0;
  logic [31:0] req_din1;
  logic        res_valid;
  logic        res_ready;
  logic [10:0] res_dout;
  logic [1:0]  res_id;
  logic [15:0] grant_cnt;

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_dout [4];

  mul_share_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_dout  (res_dout),
    .res_id    (res_id),
    .grant_cnt (grant_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [2:0] a, input logic [7:0] b);
    req_din0[i*3 +: 3] = a;
    req_din1[i*8 +: 8] = b;
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = 4'hF;
    req_din0  = '0;
    req_din1  = '0;
    res_ready = 1'b1;
    step();
    step();
    // Reset state and ready forced low while reset is held
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_dout",  32'(res_dout),  32'h0);
    check("rst_res_id",    32'(res_id),    32'h0);
    check("rst_grant_cnt", 32'(grant_cnt), 32'h0);

    // Single requester 2: 5 * -3 = -15
    ap_rst    = 1'b0;
    req_valid = 4'b0100;
    set_lane(2, 3'd5, 8'hFD);
    #1;
    check("r2_req_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;
    check("r2_res_valid", 32'(res_valid), 32'h1);
    check("r2_res_dout",  32'(res_dout),  32'h7F1);
    check("r2_res_id",    32'(res_id),    32'h2);
    check("r2_grant_cnt", 32'(grant_cnt), 32'h1);

    // Idle cycle: valid drops, data and counter hold
    step();
    check("idle_res_valid", 32'(res_valid), 32'h0);
    check("idle_res_dout",  32'(res_dout),  32'h7F1);
    check("idle_res_id",    32'(res_id),    32'h2);
    check("idle_grant_cnt", 32'(grant_cnt), 32'h1);

    // Extremes, each alone: 7*-128, 7*127, 0*-128
    set_lane(0, 3'd7, 8'h80);
    req_valid = 4'b0001;
    step();
    check("ext0_dout", 32'(res_dout), 32'h480);
    check("ext0_id",   32'(res_id),   32'h0);
    set_lane(1, 3'd7, 8'h7F);
    req_valid = 4'b0010;
    step();
    check("ext1_dout", 32'(res_dout), 32'h379);
    check("ext1_id",   32'(res_id),   32'h1);
    set_lane(3, 3'd0, 8'h80);
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    check("ext2_dout",  32'(res_dout),  32'h000);
    check("ext2_id",    32'(res_id),    32'h3);
    check("ext2_cnt",   32'(grant_cnt), 32'h4);
    check("ext2_valid", 32'(res_valid), 32'h1);

    // Fresh reset, then all four valid for 5 cycles: ids 0,1,2,3,0
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    set_lane(0, 3'd1, 8'h10); exp_dout[0] = 11'h010;  // 1*16
    set_lane(1, 3'd2, 8'hF0); exp_dout[1] = 11'h7E0;  // 2*-16
    set_lane(2, 3'd3, 8'h05); exp_dout[2] = 11'h00F;  // 3*5
    set_lane(3, 3'd4, 8'h7F); exp_dout[3] = 11'h1FC;  // 4*127
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_id",    32'(res_id),    32'(k % 4));
      check("rr_dout",  32'(res_dout),  32'(exp_dout[k % 4]));
      check("rr_valid", 32'(res_valid), 32'h1);
    end
    check("rr_cnt", 32'(grant_cnt), 32'h5);

    // Backpressure: 3 stalled cycles, nothing granted, result stable
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_req_ready", 32'(req_ready), 32'h0);
      step();
      check("bp_valid", 32'(res_valid), 32'h1);
      check("bp_dout",  32'(res_dout),  32'(exp_dout[0]));
      check("bp_id",    32'(res_id),    32'h0);
      check("bp_cnt",   32'(grant_cnt), 32'h5);
    end
    // Release: same-cycle grant to requester 1 with no bubble
    res_ready = 1'b1;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'h2);
    step();
    check("rel_id",   32'(res_id),   32'h1);
    check("rel_dout", 32'(res_dout), 32'(exp_dout[1]));
    check("rel_cnt",  32'(grant_cnt), 32'h6);

    // Mid-operation reset with rr_ptr=2 and a pending result
    ap_rst = 1'b1;
    #1;
    check("mrst_req_ready", 32'(req_ready), 32'h0);
    step();
    check("mrst_valid", 32'(res_valid), 32'h0);
    check("mrst_cnt",   32'(grant_cnt), 32'h0);
    check("mrst_dout",  32'(res_dout),  32'h0);
    ap_rst    = 1'b0;
    req_valid = 4'b1001;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    check("post_rst_id",   32'(res_id),    32'h0);
    check("post_rst_dout", 32'(res_dout),  32'(exp_dout[0]));
    check("post_rst_cnt",  32'(grant_cnt), 32'h1);

    // Counter wrap: 65535 accepts from zero, then one more
    ap_rst = 1'b1;
    step();
    ap_rst    = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 65535; k++) step();
    check("wrap_pre",  32'(grant_cnt), 32'hFFFF);
    step();
    check("wrap_post", 32'(grant_cnt), 32'h0);
    check("wrap_valid", 32'(res_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
